// File: rtl/arith_dec_renorm.sv
// Arithmetic-decoder range renormalization with byte-wise window refill.
// Define ARITH_DEC_STATS_EN to enable the byte/shift statistics counters.
module arith_dec_renorm #(
    parameter int RANGE_WIDTH  = 16,
    parameter int D_SIZE       = 5,
    parameter int WINDOW_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    init,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    input  logic [7:0]              byte_data,
    input  logic                    byte_last,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [RANGE_WIDTH-1:0]  req_rng,
    input  logic [WINDOW_WIDTH-1:0] req_dif,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RANGE_WIDTH-1:0]  out_rng,
    output logic [WINDOW_WIDTH-1:0] out_dif,
    output logic                    err,
    output logic [31:0]             stat_bytes,
    output logic [31:0]             stat_shifts
);
    localparam int CW = D_SIZE + 2;
    localparam int SW = CW + 2;
    localparam logic [RANGE_WIDTH-1:0]  RNG_MSB  = RANGE_WIDTH'(1) << (RANGE_WIDTH - 1);
    localparam logic [WINDOW_WIDTH-1:0] DIF_INIT = {1'b0, {(WINDOW_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0]    CNT_INIT = CW'(-15);
    localparam logic [D_SIZE-1:0]       D_ZERO   = D_SIZE'(RANGE_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, INIT_FILL, READY, SHIFT, FILL, RESP} state_t;

    state_t                   state_reg, state_next;
    logic [WINDOW_WIDTH-1:0]  dif_reg, dif_next;
    logic [RANGE_WIDTH-1:0]   rng_reg, rng_next;
    logic signed [CW-1:0]     cnt_reg, cnt_next;
    logic                     eos_reg, eos_next;
    logic                     err_reg, err_next;

    logic [D_SIZE-1:0]        lz, shift_d;
    logic                     rng_zero;
    logic                     fill_active, fill_step, init_take;
    logic [7:0]               fill_byte;
    logic [SW-1:0]            fill_shift;
    logic [WINDOW_WIDTH-1:0]  fill_word, ones_mask;
    logic signed [CW-1:0]     cnt_fill, cnt_shift;
    state_t                   fill_done_state;

    // Highest set bit wins because it is visited last.
    always_comb begin
        lz = D_SIZE'(RANGE_WIDTH);
        for (int i = 0; i < RANGE_WIDTH; i++) begin
            if (rng_reg[i]) lz = D_SIZE'(RANGE_WIDTH - 1 - i);
        end
    end

    assign rng_zero  = (rng_reg == '0);
    assign shift_d   = rng_zero ? D_ZERO : lz;
    assign cnt_shift = cnt_reg - $signed({2'b00, shift_d});
    assign ones_mask = ~({WINDOW_WIDTH{1'b1}} << shift_d);

    // After end of stream the window is padded with zero bytes, no handshake.
    assign fill_active = ((state_reg == INIT_FILL) || (state_reg == FILL)) && cnt_reg[CW-1];
    assign byte_ready  = fill_active && !eos_reg;
    assign fill_step   = fill_active && (eos_reg || byte_valid);
    assign fill_byte   = eos_reg ? 8'h00 : byte_data;
    assign fill_shift  = SW'(WINDOW_WIDTH - 24) - SW'(cnt_reg);
    assign fill_word   = {{(WINDOW_WIDTH-8){1'b0}}, fill_byte} << fill_shift;
    assign cnt_fill    = cnt_reg + CW'(8);
    assign fill_done_state = (state_reg == INIT_FILL) ? READY : RESP;

    assign init_take = init && ((state_reg == IDLE) || (state_reg == READY));
    assign req_ready = (state_reg == READY) && !init;
    assign out_valid = (state_reg == RESP);
    assign out_rng   = rng_reg;
    assign out_dif   = dif_reg;
    assign err       = err_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            dif_reg   <= '0;
            rng_reg   <= '0;
            cnt_reg   <= '0;
            eos_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            dif_reg   <= dif_next;
            rng_reg   <= rng_next;
            cnt_reg   <= cnt_next;
            eos_reg   <= eos_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        dif_next   = dif_reg;
        rng_next   = rng_reg;
        cnt_next   = cnt_reg;
        eos_next   = eos_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: ;
            READY: begin
                if (req_valid) begin
                    rng_next   = req_rng;
                    dif_next   = req_dif;
                    state_next = SHIFT;
                end
            end
            INIT_FILL, FILL: begin
                if (!cnt_reg[CW-1]) begin
                    state_next = fill_done_state;
                end else if (fill_step) begin
                    dif_next = dif_reg ^ fill_word;
                    cnt_next = cnt_fill;
                    if (!eos_reg && byte_last) eos_next = 1'b1;
                    if (!cnt_fill[CW-1]) state_next = fill_done_state;
                end
            end
            SHIFT: begin
                // Ones shifted into the window: ((dif + 1) << d) - 1.
                rng_next   = rng_zero ? RNG_MSB : (rng_reg << shift_d);
                dif_next   = (dif_reg << shift_d) | ones_mask;
                cnt_next   = cnt_shift;
                if (rng_zero) err_next = 1'b1;
                state_next = cnt_shift[CW-1] ? FILL : RESP;
            end
            RESP: begin
                if (out_ready) state_next = READY;
            end
            default: state_next = IDLE;
        endcase
        if (init_take) begin
            dif_next   = DIF_INIT;
            rng_next   = RNG_MSB;
            cnt_next   = CNT_INIT;
            eos_next   = 1'b0;
            err_next   = 1'b0;
            state_next = INIT_FILL;
        end
    end

`ifdef ARITH_DEC_STATS_EN
    logic [31:0] stat_bytes_reg, stat_shifts_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_bytes_reg  <= '0;
            stat_shifts_reg <= '0;
        end else if (init_take) begin
            stat_bytes_reg  <= '0;
            stat_shifts_reg <= '0;
        end else begin
            if (fill_step) stat_bytes_reg <= stat_bytes_reg + 32'd1;
            if (state_reg == SHIFT) stat_shifts_reg <= stat_shifts_reg + 32'(shift_d);
        end
    end

    assign stat_bytes  = stat_bytes_reg;
    assign stat_shifts = stat_shifts_reg;
`else
    assign stat_bytes  = '0;
    assign stat_shifts = '0;
`endif

endmodule

// File: tb/tb_arith_dec_renorm.sv
// Scoreboard bench for arith_dec_renorm: byte feeder, reference model, latency checks.
module tb_arith_dec_renorm;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        init;
    logic        byte_valid, byte_ready, byte_last;
    logic [7:0]  byte_data;
    logic        req_valid, req_ready;
    logic [15:0] req_rng;
    logic [31:0] req_dif;
    logic        out_valid, out_ready;
    logic [15:0] out_rng;
    logic [31:0] out_dif;
    logic        err;
    logic [31:0] stat_bytes, stat_shifts;

    always #5 clk = ~clk;

    arith_dec_renorm dut (
        .clk(clk), .reset_n(reset_n), .init(init),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .byte_last(byte_last), .req_valid(req_valid), .req_ready(req_ready),
        .req_rng(req_rng), .req_dif(req_dif), .out_valid(out_valid),
        .out_ready(out_ready), .out_rng(out_rng), .out_dif(out_dif), .err(err),
        .stat_bytes(stat_bytes), .stat_shifts(stat_shifts)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] rng;
        logic [31:0] dif;
        logic        err;
        int          lat;
        int          nreal;
    } exp_t;
    exp_t sb[$];

    // Byte source: {last, data}; handshake recorded at the clock edge.
    logic [8:0] fq[$];
    int hs_count = 0;

    initial begin : feeder
        bit hs;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (fq.size() > 0) begin
                byte_valid = 1'b1;
                byte_data  = fq[0][7:0];
                byte_last  = fq[0][8];
            end else begin
                byte_valid = 1'b0;
                byte_data  = 8'h00;
                byte_last  = 1'b0;
            end
            hs = byte_valid && byte_ready;
            @(posedge clk);
            if (hs && reset_n && fq.size() > 0) begin
                void'(fq.pop_front());
                hs_count++;
            end
        end
    end

    // Reference model
    logic [31:0] m_dif;
    int          m_cnt;
    bit          m_eos, m_err;
    logic [8:0]  mq[$];
    int          m_bytes, m_shifts;

    function automatic int m_lzc(input logic [15:0] r);
        int d = 0;
        while (d < 16 && !r[15-d]) d++;
        return d;
    endfunction

    task automatic m_fill(output int nsteps, output int nreal);
        logic [7:0] b;
        logic [8:0] e;
        nsteps = 0;
        nreal  = 0;
        while (m_cnt < 0) begin
            b = 8'h00;
            if (!m_eos) begin
                if (mq.size() == 0) break;
                e = mq.pop_front();
                b = e[7:0];
                if (e[8]) m_eos = 1'b1;
                nreal++;
            end
            m_dif = m_dif ^ (32'(b) << (8 - m_cnt));
            m_cnt += 8;
            nsteps++;
            m_bytes++;
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit last);
        fq.push_back({last, b});
        mq.push_back({last, b});
    endtask

    task automatic check_stats(input string tag);
`ifdef ARITH_DEC_STATS_EN
        check({tag, "_stat_bytes"}, stat_bytes, m_bytes);
        check({tag, "_stat_shifts"}, stat_shifts, m_shifts);
`else
        check({tag, "_stat_bytes"}, stat_bytes, 0);
        check({tag, "_stat_shifts"}, stat_shifts, 0);
`endif
    endtask

    task automatic do_init();
        int ns, nr, start, w;
        start   = hs_count;
        init    = 1'b1;
        m_dif   = 32'h7FFF_FFFF;
        m_cnt   = -15;
        m_eos   = 1'b0;
        m_err   = 1'b0;
        m_bytes = 0;
        m_shifts = 0;
        m_fill(ns, nr);
        @(negedge clk);
        init = 1'b0;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("init_ready", req_ready, 1);
        check("init_dif", out_dif, m_dif);
        check("init_rng", out_rng, 16'h8000);
        check("init_bytes", hs_count - start, nr);
        check("init_err", err, 0);
        check_stats("init");
        $display("init: bytes=%0d dif=%08h cnt=%0d", hs_count - start, out_dif, m_cnt);
    endtask

    task automatic send_req(input logic [15:0] rng, input logic [31:0] dif,
                            input int hold, output bit saw_br);
        exp_t e;
        int d, ns, nr, start, lat, w;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_wait", req_ready, 1);
        d = m_lzc(rng);
        if (rng == 16'h0000) begin
            d = 15;
            e.rng = 16'h8000;
            m_err = 1'b1;
        end else begin
            e.rng = rng << d;
        end
        m_dif = (dif << d) | ((32'h1 << d) - 32'h1);
        m_cnt -= d;
        m_shifts += d;
        m_fill(ns, nr);
        e.dif = m_dif;
        e.err = m_err;
        e.lat = 2 + ns;
        e.nreal = nr;
        sb.push_back(e);

        start     = hs_count;
        req_valid = 1'b1;
        req_rng   = rng;
        req_dif   = dif;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        saw_br = 1'b0;
        while (!out_valid && lat < 60) begin
            if (byte_ready) saw_br = 1'b1;
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check("resp_valid", out_valid, 1);
        check("resp_latency", lat, e.lat);
        check("resp_rng", out_rng, e.rng);
        check("resp_dif", out_dif, e.dif);
        check("resp_err", err, e.err);
        check("resp_bytes", hs_count - start, e.nreal);
        check_stats("resp");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_rng", out_rng, e.rng);
            check("hold_dif", out_dif, e.dif);
        end
        $display("req rng=%04h dif=%08h -> rng=%04h dif=%08h err=%0d lat=%0d bytes=%0d",
                 rng, dif, out_rng, out_dif, err, lat, hs_count - start);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_rng"}, out_rng, 0);
        check({tag, "_out_dif"}, out_dif, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_stat_bytes"}, stat_bytes, 0);
        check({tag, "_stat_shifts"}, stat_shifts, 0);
    endtask

    initial begin
        bit saw;
        init      = 1'b0;
        req_valid = 1'b0;
        req_rng   = '0;
        req_dif   = '0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        push_byte(8'h12, 1'b0);
        push_byte(8'h34, 1'b0);
        for (int i = 0; i < 40; i++) push_byte(8'($urandom_range(0, 255)), 1'b0);
        do_init();
        check("init_dif_known", out_dif, 32'h76E5_FFFF);

        send_req(16'h0F00, 32'h1234_5678, 0, saw);
        send_req(16'h8001, $urandom, 0, saw);
        check("norm_no_byte_ready", saw, 0);
        for (int i = 0; i < 6; i++)
            send_req(16'($urandom_range(1, 65535)), $urandom, 0, saw);

        send_req(16'h0000, $urandom, 0, saw);
        send_req(16'h0123, $urandom, 0, saw);
        send_req(16'h4000, $urandom, 0, saw);

        // End-of-stream: last byte during init, later refills are zero pads.
        fq.delete();
        mq.delete();
        push_byte(8'hAB, 1'b0);
        push_byte(8'hCD, 1'b1);
        do_init();
        send_req(16'h0001, $urandom, 0, saw);
        check("eos_no_byte_ready", saw, 0);
        send_req(16'h00F0, $urandom, 0, saw);
        check("eos_no_byte_ready2", saw, 0);

        send_req(16'h0300, $urandom, 5, saw);

        // Stall in FILL on an empty byte source, then reset asynchronously.
        fq.delete();
        mq.delete();
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        do_init();
        req_valid = 1'b1;
        req_rng   = 16'h0001;
        req_dif   = $urandom;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("stall_byte_ready", byte_ready, 1);
        check("stall_out_valid", out_valid, 0);
        check("stall_out_rng", out_rng, 16'h8000);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");
        $display("reset mid-fill done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
